// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants: widths used by conv, FC, requant, ReLU and pooling.
package lenet_pkg;

    localparam int ACC_WIDTH   = 20;
    localparam int BIAS_WIDTH  = 16;
    localparam int DATA_SIZE   = 8;
    localparam int SHIFT_WIDTH = 4;

    localparam logic signed [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE - 1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE - 1){1'b0}}};

endpackage

// File: rtl/round_shift_sat.sv
// Round-half-up arithmetic right shift followed by saturation to a signed DATA_SIZE result.
// Purely combinational; the FC layer reuses it.
module round_shift_sat #(
    parameter int SUM_WIDTH   = 22,
    parameter int SHIFT_WIDTH = 4,
    parameter int DATA_SIZE   = 8
) (
    input  logic signed [SUM_WIDTH-1:0]   sum,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [DATA_SIZE-1:0]   data,
    output logic                          sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int QW = SUM_WIDTH + 1;
    localparam logic signed [QW-1:0] QMAX = QW'((2 ** (DATA_SIZE - 1)) - 1);
    localparam logic signed [QW-1:0] QMIN = -QW'(2 ** (DATA_SIZE - 1));

    logic signed [QW-1:0] sum_ext;
    logic signed [QW-1:0] rnd;
    logic signed [QW-1:0] q;

    always_comb begin
        sum_ext = {sum[SUM_WIDTH-1], sum};
        rnd     = (shift == '0) ? '0 : (QW'(1) << (int'(shift) - 1));
        q       = (sum_ext + rnd) >>> shift;
        data    = q[DATA_SIZE-1:0];
        sat     = 1'b0;
        if (q > QMAX) begin
            data = {1'b0, {(DATA_SIZE - 1){1'b1}}};
            sat  = 1'b1;
        end else if (q < QMIN) begin
            data = {1'b1, {(DATA_SIZE - 1){1'b0}}};
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/requant_sat_stream.sv
// Two-stage valid/ready requantizer: bias add, rounded shift, saturate to DATA_SIZE, and count
// clipped beats handed downstream.
module requant_sat_stream #(
    parameter int ACC_WIDTH   = lenet_pkg::ACC_WIDTH,
    parameter int BIAS_WIDTH  = lenet_pkg::BIAS_WIDTH,
    parameter int DATA_SIZE   = lenet_pkg::DATA_SIZE,
    parameter int SHIFT_WIDTH = lenet_pkg::SHIFT_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [ACC_WIDTH-1:0]   in_acc,
    input  logic signed [BIAS_WIDTH-1:0]  in_bias,
    input  logic        [SHIFT_WIDTH-1:0] in_shift,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic        [DATA_SIZE-1:0]   out_data,
    output logic                          out_last,
    output logic                          out_sat,
    input  logic                          sat_clr,
    output logic        [CNT_WIDTH-1:0]   sat_count
);

    localparam int SUM_WIDTH = ACC_WIDTH + 2;

    logic                          s1_valid_q, s1_valid_d;
    logic signed [SUM_WIDTH-1:0]   s1_sum_q, s1_sum_d;
    logic        [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
    logic                          s1_last_q, s1_last_d;
    logic                          s2_valid_q, s2_valid_d;
    logic        [DATA_SIZE-1:0]   out_data_q, out_data_d;
    logic                          out_last_q, out_last_d;
    logic                          out_sat_q, out_sat_d;
    logic        [CNT_WIDTH-1:0]   sat_count_q, sat_count_d;
    logic                          s1_en, s2_en;
    logic signed [DATA_SIZE-1:0]   rs_data;
    logic                          rs_sat;

    round_shift_sat #(
        .SUM_WIDTH  (SUM_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH),
        .DATA_SIZE  (DATA_SIZE)
    ) u_round_shift_sat (
        .sum  (s1_sum_q),
        .shift(s1_shift_q),
        .data (rs_data),
        .sat  (rs_sat)
    );

    always_comb begin
        s2_en       = !s2_valid_q || out_ready;
        s1_en       = !s1_valid_q || s2_en;
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_shift_d  = s1_shift_q;
        s1_last_d   = s1_last_q;
        s2_valid_d  = s2_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sat_d   = out_sat_q;
        sat_count_d = sat_count_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            s1_sum_d   = SUM_WIDTH'(in_acc) + SUM_WIDTH'(in_bias);
            s1_shift_d = in_shift;
            s1_last_d  = in_last;
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            out_data_d = rs_data;
            out_last_d = s1_last_q;
            out_sat_d  = rs_sat;
        end
        // Clear wins over a simultaneous clipped transfer; count saturates at all-ones.
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (s2_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_shift_q  <= s1_shift_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = s1_en;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule
